// File: rtl/rk_loop_ctrl_if.sv
// ---------------------------------------------------------------------------
// rk_loop_ctrl_if
//
// Bundles the signals between the RK loop controller and the two blocks it
// drives: the external magnitude comparator and the RK slope datapath.
//
//   cmp_a, cmp_b              comparator operands (t_cur, t_end)
//   cmp_eq, cmp_lt, cmp_gt    comparator results for cmp_a vs cmp_b
//   stage_req, stage_sel      stage request and active stage (0=k1 .. 3=k4)
//   stage_ack                 one-cycle stage-complete pulse from the datapath
//   y_update                  one-cycle pulse telling the datapath to commit
//
// Modports: master = controller side, slave = comparator/datapath side.
// ---------------------------------------------------------------------------
interface rk_loop_ctrl_if #(
  parameter int N = 32
);
  logic [N-1:0] cmp_a;
  logic [N-1:0] cmp_b;
  logic         cmp_eq;
  logic         cmp_lt;
  logic         cmp_gt;
  logic         stage_req;
  logic [1:0]   stage_sel;
  logic         stage_ack;
  logic         y_update;

  modport master (
    output cmp_a, cmp_b, stage_req, stage_sel, y_update,
    input  cmp_eq, cmp_lt, cmp_gt, stage_ack
  );

  modport slave (
    input  cmp_a, cmp_b, stage_req, stage_sel, y_update,
    output cmp_eq, cmp_lt, cmp_gt, stage_ack
  );
endinterface

// File: rtl/rk_loop_ctrl.sv
// ---------------------------------------------------------------------------
// rk_loop_ctrl
//
// Sequencing controller for the Runge-Kutta integration loop. Owns the time
// register, feeds t_cur/t_end to an external comparator, walks the datapath
// through the k1..k4 slope stages with a req/ack handshake and then commits
// the step (y_update) while advancing t_cur by h.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            begin integration (only honoured in IDLE)
//   t0, h, t_end     initial time, step size, end time (unsigned, N bits)
//   dp               rk_loop_ctrl_if.master: comparator + datapath handshake
//   t_cur            current time
//   iter_cnt         completed iterations, saturating at all-ones
//   busy             high whenever not IDLE
//   done             one-cycle pulse when integration finishes
//
// Optional feature, enabled by defining RK_ITER_LIMIT_EN:
//   max_iter  (in)   iteration cap, 0 = no cap
//   limit_hit (out)  sticky flag, set when the cap ended the run
// ---------------------------------------------------------------------------
module rk_loop_ctrl #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  t0,
  input  logic [N-1:0]  h,
  input  logic [N-1:0]  t_end,
`ifdef RK_ITER_LIMIT_EN
  input  logic [CW-1:0] max_iter,
  output logic          limit_hit,
`endif
  rk_loop_ctrl_if.master dp,
  output logic [N-1:0]  t_cur,
  output logic [CW-1:0] iter_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STAGE,
    UPDATE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]    stage_sel_q;
  logic [N:0]    t_sum;
  logic          carry;
  logic [CW-1:0] iter_inc;
  logic          cmp_go;
  logic          cap_reached;

  // One extra bit on the adder so the overflow of t_cur + h is visible.
  assign t_sum    = {1'b0, t_cur} + {1'b0, h};
  assign carry    = t_sum[N];
  assign iter_inc = (&iter_cnt) ? iter_cnt : iter_cnt + 1'b1;

  // Only a clean one-hot "less than" keeps the loop going; EQ, GT and any
  // malformed code from the comparator end the integration.
  assign cmp_go = dp.cmp_lt & ~dp.cmp_eq & ~dp.cmp_gt;

`ifdef RK_ITER_LIMIT_EN
  assign cap_reached = (max_iter != '0) && (iter_inc == max_iter);
`else
  assign cap_reached = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = cmp_go ? STAGE : DONE;
      STAGE:   if (dp.stage_ack && (stage_sel_q == 2'd3)) state_nxt = UPDATE;
      UPDATE:  state_nxt = (carry || cap_reached) ? DONE : CHECK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Time, iteration count and stage selector. A carry out of the time add
  // pins t_cur at all-ones so the final value never wraps below t_end.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_cur       <= '0;
      iter_cnt    <= '0;
      stage_sel_q <= 2'd0;
`ifdef RK_ITER_LIMIT_EN
      limit_hit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            t_cur     <= t0;
            iter_cnt  <= '0;
`ifdef RK_ITER_LIMIT_EN
            limit_hit <= 1'b0;
`endif
          end
        end
        CHECK: begin
          if (cmp_go) stage_sel_q <= 2'd0;
        end
        STAGE: begin
          if (dp.stage_ack && (stage_sel_q != 2'd3)) stage_sel_q <= stage_sel_q + 2'd1;
        end
        UPDATE: begin
          t_cur    <= carry ? '1 : t_sum[N-1:0];
          iter_cnt <= iter_inc;
`ifdef RK_ITER_LIMIT_EN
          if (cap_reached) limit_hit <= 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign dp.cmp_a     = t_cur;
  assign dp.cmp_b     = t_end;
  assign dp.stage_sel = stage_sel_q;
  assign dp.stage_req = (state == STAGE);
  assign dp.y_update  = (state == UPDATE);
  assign done         = (state == DONE);
  assign busy         = (state != IDLE);

endmodule
